// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor that processes WIDTH-bit operands CHUNK bits per clock
// through one ripple slice. The carry between chunks is held in a flop.
module seq_addsub #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned CHUNK = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;

  generate
    if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("seq_addsub: WIDTH must be an integer multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, z_q, z_d;
  logic             c_q, c_d, mode_q, mode_d;
  logic             carry_q, carry_d, ovf_q, ovf_d, done_q, done_d;

  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic             c_rip, c_msb;
  logic [WIDTH-1:0] acc_next;

  // Operands shift right each cycle, so the active chunk is always the low CHUNK bits.
  assign a_ch = a_q[CHUNK-1:0];
  assign b_ch = b_q[CHUNK-1:0];

  always_comb begin
    s_ch  = '0;
    c_rip = c_q;
    c_msb = 1'b0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      s_ch[i] = a_ch[i] ^ b_ch[i] ^ c_rip;
      c_msb   = c_rip;
      c_rip   = (a_ch[i] & b_ch[i]) | (c_rip & (a_ch[i] ^ b_ch[i]));
    end
  end

  // Sum chunks enter at the top; after NCH steps chunk 0 sits at the bottom.
  assign acc_next = (acc_q >> CHUNK) | (WIDTH'(s_ch) << (WIDTH - CHUNK));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    z_d     = z_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = x;
          b_d     = mode ? ~y : y;
          c_d     = cin ^ mode;
          mode_d  = mode;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        acc_d = acc_next;
        c_d   = c_rip;
        k_d   = k_q + KW'(1);
        if (k_q == KW'(NCH - 1)) begin
          // Subtract runs as x + ~y + ~cin, so the inverted carry-out is the borrow.
          z_d     = acc_next;
          carry_d = c_rip ^ mode_q;
          ovf_d   = c_msb ^ c_rip;
          done_d  = 1'b1;
          k_d     = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      mode_q  <= 1'b0;
      acc_q   <= '0;
      z_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign ready    = (state_q == StIdle);
  assign done     = done_q;
  assign z        = z_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule
